// File: rtl/fifo_rd_ctrl_pkg.sv
// Shared constants and state encoding for the FIFO read-side controller.
package fifo_rd_ctrl_pkg;

  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned FIFO_WIDTH = 8;
  localparam int unsigned PTR_W      = 3;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    INIT   = 2'b00,
    NO_OP  = 2'b01,
    READ   = 2'b10,
    RD_ERR = 2'b11
  } rd_state_e;

endpackage

// File: rtl/fifo_rd_mux8.sv
// 8-to-1 selector of storage entries, indexed by the read pointer.
module fifo_rd_mux8
  import fifo_rd_ctrl_pkg::*;
(
  input  logic [FIFO_DEPTH*FIFO_WIDTH-1:0] mem_i,
  input  logic [PTR_W-1:0]                 sel_i,
  output logic [FIFO_WIDTH-1:0]            data_o
);

  always_comb begin
    data_o = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (sel_i == PTR_W'(i)) data_o = mem_i[i*FIFO_WIDTH +: FIFO_WIDTH];
    end
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// FIFO read-side controller: accepts or rejects reads against data_count,
// returns registered data and ack/err/dec pulses one cycle later.
module fifo_rd_ctrl
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH,
  parameter int unsigned WIDTH = FIFO_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   rd_en,
  input  logic [CNT_W-1:0]       data_count,
  input  logic [DEPTH*WIDTH-1:0] mem_q,
  output logic [WIDTH-1:0]       d_out,
  output logic [PTR_W-1:0]       rd_ptr,
  output logic                   rd_ack,
  output logic                   rd_err,
  output logic                   dec,
  output logic                   empty
);

  rd_state_e        state_q, state_d;
  logic [WIDTH-1:0] d_out_q, d_out_d, rd_data;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             dec_q, dec_d;

  assign empty = (data_count == CNT_W'(0));

  fifo_rd_mux8 u_mux (
    .mem_i  (mem_q),
    .sel_i  (rd_ptr_q),
    .data_o (rd_data)
  );

  // Every state decides the same way; the count present at this edge governs.
  always_comb begin
    state_d  = state_q;
    d_out_d  = d_out_q;
    rd_ptr_d = rd_ptr_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    dec_d    = 1'b0;
    if (!rd_en) begin
      state_d = NO_OP;
    end else if (!empty) begin
      state_d  = READ;
      d_out_d  = rd_data;
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      ack_d    = 1'b1;
      dec_d    = 1'b1;
    end else begin
      state_d = RD_ERR;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= INIT;
      d_out_q  <= '0;
      rd_ptr_q <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      dec_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      d_out_q  <= d_out_d;
      rd_ptr_q <= rd_ptr_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      dec_q    <= dec_d;
    end
  end

  assign d_out  = d_out_q;
  assign rd_ptr = rd_ptr_q;
  assign rd_ack = ack_q;
  assign rd_err = err_q;
  assign dec    = dec_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: directed scenarios plus random traffic
// compared every cycle against a behavioural read-side model.
module tb_fifo_rd_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rd_en = 1'b0;
  logic [3:0]  data_count = 4'd0;
  logic [63:0] mem_q;
  logic [7:0]  d_out;
  logic [2:0]  rd_ptr;
  logic        rd_ack, rd_err, dec, empty;

  logic [7:0]  mem_arr [8];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // model of the read side
  int       m_ptr = 0;
  int       m_dout = 0;
  bit       m_ack = 0, m_err = 0, m_dec = 0;

  fifo_rd_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rd_en      (rd_en),
    .data_count (data_count),
    .mem_q      (mem_q),
    .d_out      (d_out),
    .rd_ptr     (rd_ptr),
    .rd_ack     (rd_ack),
    .rd_err     (rd_err),
    .dec        (dec),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 8; i++) mem_q[i*8 +: 8] = mem_arr[i];
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference: reads consume the entry at the pointer while the count is nonzero.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ptr = 0; m_dout = 0; m_ack = 0; m_err = 0; m_dec = 0;
    end else if (rd_en && data_count != 0) begin
      m_dout = int'(mem_arr[m_ptr]);
      m_ptr  = (m_ptr + 1) % 8;
      m_ack = 1; m_err = 0; m_dec = 1;
    end else begin
      m_ack = 0; m_dec = 0;
      m_err = rd_en;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_dout",  int'(d_out),  m_dout);
      check("m_ptr",   int'(rd_ptr), m_ptr);
      check("m_ack",   int'(rd_ack), int'(m_ack));
      check("m_err",   int'(rd_err), int'(m_err));
      check("m_dec",   int'(dec),    int'(m_dec));
      check("m_empty", int'(empty),  int'(data_count == 4'd0));
      check("ack_err_excl", int'(rd_ack & rd_err), 0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem_arr[i] = 8'h00;
    reset_n = 1'b0;
    repeat (2) cyc();
    reset_n = 1'b1;
    chk_en = 1'b1;

    // single read of entry 0
    mem_arr[0] = 8'hA5;
    mem_arr[1] = 8'h3C;
    data_count = 4'd3;
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    check("single_dout", int'(d_out),  8'hA5);
    check("single_ack",  int'(rd_ack), 1);
    check("single_dec",  int'(dec),    1);
    check("single_ptr",  int'(rd_ptr), 1);
    check("single_err",  int'(rd_err), 0);
    cyc();
    check("single_idle", int'({rd_ack, rd_err, dec}), 0);
    check("single_hold", int'(d_out), 8'hA5);

    // read from an empty FIFO
    data_count = 4'd0;
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    check("empty_err",   int'(rd_err), 1);
    check("empty_ack",   int'(rd_ack), 0);
    check("empty_dec",   int'(dec),    0);
    check("empty_dout",  int'(d_out),  8'hA5);
    check("empty_ptr",   int'(rd_ptr), 1);
    check("empty_flag",  int'(empty),  1);

    // asynchronous reset mid-cycle, no clock edge
    cyc();
    #1;
    reset_n = 1'b0;
    #1;
    check("rst_dout",  int'(d_out),  0);
    check("rst_ptr",   int'(rd_ptr), 0);
    check("rst_flags", int'({rd_ack, rd_err, dec}), 0);
    cyc();
    reset_n = 1'b1;

    // full drain with wrap-around, count follows each accepted read
    for (int i = 0; i < 8; i++) mem_arr[i] = 8'(8'h10 + i);
    rd_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      data_count = 4'(8 - i);
      cyc();
      if (i < 8) begin
        check("wrap_ack",  int'(rd_ack), 1);
        check("wrap_dout", int'(d_out),  8'h10 + i);
        check("wrap_ptr",  int'(rd_ptr), (i + 1) % 8);
      end else begin
        check("wrap_err",  int'(rd_err), 1);
        check("wrap_ack9", int'(rd_ack), 0);
        check("wrap_ptr9", int'(rd_ptr), 0);
        check("wrap_dout9", int'(d_out), 8'h17);
      end
    end
    rd_en = 1'b0;
    cyc();

    // reset lands between a read request and its edge
    data_count = 4'd2;
    rd_en = 1'b1;
    cyc();
    check("pre_rst_ptr", int'(rd_ptr), 1);
    #3;
    reset_n = 1'b0;
    cyc();
    check("midrst_dec", int'(dec),    0);
    check("midrst_ptr", int'(rd_ptr), 0);
    rd_en = 1'b0;
    reset_n = 1'b1;
    cyc();
    check("midrst_rel_ptr", int'(rd_ptr), 0);
    check("midrst_rel_dec", int'(dec),    0);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      rd_en = 1'($urandom_range(0, 3) != 0);
      data_count = 4'($urandom_range(0, 8));
      if ($urandom_range(0, 7) == 0) mem_arr[$urandom_range(0, 7)] = 8'($urandom);
      if ($urandom_range(0, 60) == 0) begin
        #($urandom_range(1, 5));
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
      end else begin
        cyc();
      end
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 Parameters: DEPTH, default 8, number of storage entries; WIDTH, default 8, bits per entry. The FIFO is fixed at 8 x 8.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 rd_en  input  1  read request, sampled on the rising edge of clk.
REQ-005 data_count  input  4  current occupancy (0..8), driven by the write side.
REQ-006 mem_q  input  64  concatenated storage outputs; entry i occupies bits [8i+7:8i].
REQ-007 d_out  output  8  read data, registered.
REQ-008 rd_ptr  output  3  read pointer, registered.
REQ-009 rd_ack  output  1  read accepted in the previous cycle, registered.
REQ-010 rd_err  output  1  read rejected in the previous cycle (FIFO was empty), registered.
REQ-011 dec  output  1  one-cycle pulse telling the write side to decrement data_count, registered.
REQ-012 empty  output  1  combinational; equals (data_count == 0).

Function
REQ-013 The state register SHALL have four states: INIT, NO_OP, READ, RD_ERR.
REQ-014 Next-state rule, applied identically from every state:
- rd_en=0 -> NO_OP
- rd_en=1 and data_count!=0 -> READ
- rd_en=1 and data_count==0 -> RD_ERR
REQ-015 On an accepted read, the clock edge SHALL do all of the following in that edge:
- capture d_out <= mem_q entry[rd_ptr]
- advance rd_ptr by 1
- set rd_ack=1 and dec=1
Read latency is 1 cycle, rd_en edge to valid d_out.
REQ-016 rd_ptr SHALL wrap from 7 to 0 with no extra cycle.
REQ-017 On a rejected read, rd_err SHALL be 1 for one cycle; d_out, rd_ptr and dec SHALL be unchanged (dec stays 0).
REQ-018 When rd_en=0, d_out and rd_ptr SHALL hold; rd_ack, rd_err and dec SHALL be 0.
REQ-019 rd_ack, rd_err and dec SHALL each be 1 only in the cycle following the request; rd_ack and rd_err are never both 1.
REQ-020 Back-to-back reads SHALL be supported every cycle. Each read is decided on the data_count present at its edge.
REQ-021 A simultaneous write on the write side SHALL NOT affect the current read decision: data_count sampled at the edge governs.
REQ-022 data_count values above 8 are illegal; behaviour is then don't-care, but rd_ptr must stay within 3 bits.

Reset
REQ-023 While reset_n=0, the block SHALL hold state=INIT, rd_ptr=0, d_out=8'h00, and rd_ack=rd_err=dec=0. Reset takes effect immediately, with no clock.
REQ-024 A reset asserted during a read SHALL abort it: no dec pulse is issued after reset asserts.
REQ-025 The first rising edge after reset_n rises SHALL apply REQ-014 normally.

Structure
REQ-026 A shared package SHALL hold:
- the state encoding (INIT=2'b00, NO_OP=2'b01, READ=2'b10, RD_ERR=2'b11)
- the DEPTH/WIDTH constants
- the pointer width (3)
REQ-027 Entry selection SHALL live in one sub-module, fifo_rd_mux8: an 8-to-1 mux of 8-bit entries selected by rd_ptr.
REQ-028 The next-state/output logic and the registers SHALL be in separate processes within fifo_rd_ctrl.

Verification
REQ-029 Reset scenario: drive reset_n=0 mid-cycle with no clock edge -> d_out=00, rd_ptr=0, and all flags 0 immediately.
REQ-030 Single read: data_count=3, entry0=8'hA5, one-cycle rd_en -> next cycle d_out=A5, rd_ack=1, dec=1, rd_ptr=1; the cycle after, all flags are 0.
REQ-031 Empty read: data_count=0, rd_en=1 -> rd_err=1, rd_ack=0, dec=0; d_out and rd_ptr unchanged; empty=1.
REQ-032 Wrap-around: entries 0..7 = 8'h10..8'h17, data_count=8, rd_en held 9 cycles with count tracking dec:
- 8 acks with d_out 10..17 in order
- rd_ptr wraps 7->0
- the 9th request gives rd_err=1
REQ-033 Mid-read reset: rd_en=1 with data_count=2, then reset_n=0 before the next edge -> no dec pulse; rd_ptr=0 after release.
